swan_mode_ctrl: RTL
===================

SWAN_MODE_CTRL -- requirements
Module: swan_mode_ctrl

Parameters
REQ-001 BLOCK_SIZE, default 128, block width in bits: 64, 128 or 256.
REQ-002 KEY_SIZE, default 256, key width in bits: 128 or 256.
REQ-003 CNT_W, default 16, width of the block counter.

Interface
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 msg_start  in  1  one-cycle request to begin a message; sampled only in IDLE.
REQ-007 cfg_cbc  in  1  0 = ECB, 1 = CBC; latched on accepted msg_start.
REQ-008 cfg_dec  in  1  0 = encrypt, 1 = decrypt; latched on accepted msg_start.
REQ-009 key_in  in  KEY_SIZE  cipher key; latched on accepted msg_start.
REQ-010 iv_in  in  BLOCK_SIZE  CBC initial vector; latched into chain register on accepted msg_start.
REQ-011 din / din_valid / din_last / din_ready  in/in/in/out  BLOCK_SIZE/1/1/1  input block stream.
REQ-012 dout / dout_valid / dout_last / dout_ready  out/out/out/in  BLOCK_SIZE/1/1/1  output block stream.
REQ-013 core_key / core_dec / core_inp / core_start  out  KEY_SIZE/1/BLOCK_SIZE/1  drive to the external SWAN core.
REQ-014 core_out / core_ready  in  BLOCK_SIZE/1  result from the core; core_ready is a one-cycle pulse.
REQ-015 busy / blk_cnt  out  1/CNT_W  busy = state not IDLE; blk_cnt = blocks output in the current message.

Function
REQ-016 States: IDLE, WAIT_IN, RUN, HOLD.
REQ-017 IDLE→WAIT_IN on msg_start: latch cfg, key and chain=iv_in; clear blk_cnt.
REQ-018 din_ready = 1 only in WAIT_IN; a transfer occurs when din_valid && din_ready.
REQ-019 On a din transfer:
- capture din into the saved-input register and din_last into the last flag;
- assert core_start for exactly the next cycle;
- go to RUN.
REQ-020 core_inp = saved ^ chain when CBC encrypt; otherwise core_inp = saved.
REQ-021 core_inp, core_key and core_dec are registered and held stable from the core_start cycle until core_ready is sampled.
REQ-022 core_ready in RUN: capture the result into dout and go to HOLD.
- Result = core_out ^ chain for CBC decrypt; core_out otherwise.
- core_ready in any other state is ignored.
REQ-023 Chain update on core_ready, CBC only: encrypt chain = core_out; decrypt chain = saved input.
REQ-024 dout_valid = 1 in HOLD; dout_last = the last flag; dout holds stable until dout_ready.
REQ-025 On a HOLD transfer (dout_ready && dout_valid), blk_cnt increments, saturating at all-ones.
- Next state: IDLE if last flag, else WAIT_IN.
REQ-026 Minimum latency per block = 1 cycle (din accept) + core latency + 1 cycle (HOLD).
- With dout_ready held high, HOLD lasts one cycle.
REQ-027 msg_start outside IDLE is ignored; latched cfg, key and chain are unchanged.
REQ-028 din_valid with din_last=1 on the first block forms a one-block message.
- A message never ends without din_last.
REQ-029 Blocks are processed strictly in order, with one block in flight at a time.
REQ-030 All arithmetic is bitwise XOR at BLOCK_SIZE width; there is no padding and no partial blocks.

Reset
REQ-031 rst low at any time, including mid-RUN, immediately forces:
- state IDLE;
- din_ready, dout_valid, dout_last, core_start, busy = 0;
- dout, core_inp, core_key, chain, saved, blk_cnt = 0; core_dec = 0.
REQ-032 After rst deasserts, a core_ready pulse from an aborted operation is ignored.

Verification
REQ-033 Core = SWAN128K256 encrypt, key all-ones, ECB, single block din=f0debc9a78563412f0debc9a78563412, last=1:
- dout=bc2b49e1f1407a5d9cf78ff7db6c0634;
- dout_last=1; blk_cnt=1; returns to IDLE.
REQ-034 Same core, CBC, iv=0, two blocks f0debc9a78563412f0debc9a78563412 then 4cf5f57b89164e4f6c29336da33a3226:
- both outputs = bc2b49e1f1407a5d9cf78ff7db6c0634;
- blk_cnt=2.
REQ-035 Decrypt core, CBC, iv=0, two blocks of bc2b49e1f1407a5d9cf78ff7db6c0634:
- outputs f0debc9a78563412f0debc9a78563412 then 4cf5f57b89164e4f6c29336da33a3226.
REQ-036 dout_ready held low 5 cycles in HOLD:
- dout stable, din_ready=0;
- a msg_start pulse in that window has no effect.
REQ-037 rst pulsed low mid-RUN, then a core_ready pulse arrives:
- all outputs at reset values;
- dout_valid stays 0; state stays IDLE.
REQ-038 Random din_valid/dout_ready back-pressure over 50 ECB blocks:
- outputs match the reference model in order;
- blk_cnt=50; dout_last only on the final block.

Source files
------------

// File: rtl/swan_mode_ctrl.sv
// ---------------------------------------------------------------------------
// swan_mode_ctrl
//
// Block-mode wrapper around an external SWAN block cipher core. Accepts a
// stream of BLOCK_SIZE-bit blocks, runs each one through the core in ECB or
// CBC mode (encrypt or decrypt), and presents the results on an output stream.
// Exactly one block is in flight at any time.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   msg_start                    begin a message (honoured only when idle)
//   cfg_cbc, cfg_dec             mode select, latched at message start
//   key_in, iv_in                key and CBC IV, latched at message start
//   din/din_valid/din_last/din_ready      input block stream
//   dout/dout_valid/dout_last/dout_ready  output block stream
//   core_key/core_dec/core_inp/core_start request to the cipher core
//   core_out/core_ready          result from the cipher core (ready = pulse)
//   busy                         high whenever a message is in progress
//   blk_cnt                      blocks delivered in the current message
// ---------------------------------------------------------------------------
module swan_mode_ctrl #(
    parameter int unsigned BLOCK_SIZE = 128,
    parameter int unsigned KEY_SIZE   = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_start,
    input  logic                  cfg_cbc,
    input  logic                  cfg_dec,
    input  logic [KEY_SIZE-1:0]   key_in,
    input  logic [BLOCK_SIZE-1:0] iv_in,
    input  logic [BLOCK_SIZE-1:0] din,
    input  logic                  din_valid,
    input  logic                  din_last,
    output logic                  din_ready,
    output logic [BLOCK_SIZE-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready,
    output logic [KEY_SIZE-1:0]   core_key,
    output logic                  core_dec,
    output logic [BLOCK_SIZE-1:0] core_inp,
    output logic                  core_start,
    input  logic [BLOCK_SIZE-1:0] core_out,
    input  logic                  core_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      blk_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_IN = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic                  cbc_q,    cbc_d;
    logic                  dec_q,    dec_d;
    logic [KEY_SIZE-1:0]   key_q,    key_d;
    logic [BLOCK_SIZE-1:0] chain_q,  chain_d;
    logic [BLOCK_SIZE-1:0] saved_q,  saved_d;
    logic                  last_q,   last_d;
    logic [BLOCK_SIZE-1:0] inp_q,    inp_d;
    logic                  start_q,  start_d;
    logic [BLOCK_SIZE-1:0] dout_q,   dout_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    always_comb begin
        state_d = state_q;
        cbc_d   = cbc_q;
        dec_d   = dec_q;
        key_d   = key_q;
        chain_d = chain_q;
        saved_d = saved_q;
        last_d  = last_q;
        inp_d   = inp_q;
        start_d = 1'b0;
        dout_d  = dout_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (msg_start) begin
                    cbc_d   = cfg_cbc;
                    dec_d   = cfg_dec;
                    key_d   = key_in;
                    chain_d = iv_in;
                    cnt_d   = '0;
                    state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (din_valid) begin
                    saved_d = din;
                    last_d  = din_last;
                    // core input is computed from din directly; it equals
                    // saved ^ chain because saved is loaded on the same edge
                    inp_d   = (cbc_q && !dec_q) ? (din ^ chain_q) : din;
                    start_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (core_ready) begin
                    dout_d = (cbc_q && dec_q) ? (core_out ^ chain_q) : core_out;
                    if (cbc_q) begin
                        chain_d = dec_q ? saved_q : core_out;
                    end
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (dout_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = last_q ? S_IDLE : S_WAIT_IN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cbc_q   <= 1'b0;
            dec_q   <= 1'b0;
            key_q   <= '0;
            chain_q <= '0;
            saved_q <= '0;
            last_q  <= 1'b0;
            inp_q   <= '0;
            start_q <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cbc_q   <= cbc_d;
            dec_q   <= dec_d;
            key_q   <= key_d;
            chain_q <= chain_d;
            saved_q <= saved_d;
            last_q  <= last_d;
            inp_q   <= inp_d;
            start_q <= start_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign din_ready  = (state_q == S_WAIT_IN);
    assign dout_valid = (state_q == S_HOLD);
    // last flag persists after the message ends; only expose it with valid data
    assign dout_last  = (state_q == S_HOLD) && last_q;
    assign dout       = dout_q;
    assign busy       = (state_q != S_IDLE);
    assign blk_cnt    = cnt_q;
    assign core_key   = key_q;
    assign core_dec   = dec_q;
    assign core_inp   = inp_q;
    assign core_start = start_q;

endmodule
